// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_pkg                                                                   |
// | Constants and state encoding shared by the UART receiver and transmitter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// +----------------------------------------------------------------------------+
// | uart_rx_sampler                                                            |
// | Synchronizes rx_serial_in and produces the bit value used for decisions;   |
// | RX_MAJORITY_VOTE_EN selects a 3-tap majority vote over recent samples.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module uart_rx_sampler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_serial_in,
    output logic rxs,
    output logic bit_val
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_serial_in};
    end

    // Chain resets to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;
    logic [1:0] hist_d;

    always_comb begin
        hist_d = {hist_q[0], rxs};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign bit_val = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign bit_val = rxs;
`endif

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// +----------------------------------------------------------------------------+
// | uart_receiver                                                              |
// | 8N1 UART receiver with one-entry ready/valid holding register, framing     |
// | error and overrun pulses. Optional macro: RX_MAJORITY_VOTE_EN.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial_in,
    input  logic       rx_data_ready,
    output logic       rx_data_valid,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int                CNT_W     = $clog2(OVERSAMPLE);
    localparam int                IDX_W     = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(UART_DATA_BITS - 1);

    logic rxs;
    logic bit_val;

    uart_rx_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_serial_in (rx_serial_in),
        .rxs          (rxs),
        .bit_val      (bit_val)
    );

    rx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      deliver;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        if (valid_q && rx_data_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {bit_val, shreg_q[UART_DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (bit_val) begin
                        state_d = IDLE;
                        deliver = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // A byte may load in the same cycle the host consumes the previous one.
        if (deliver) begin
            if (!valid_q || rx_data_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data_valid = valid_q;
    assign rx_data       = data_q;
    assign rx_frame_err  = frame_err_q;
    assign rx_overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// +----------------------------------------------------------------------------+
// | tb_uart_receiver                                                           |
// | Frame-level reference model of uart_receiver with randomized traffic.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_uart_receiver;

    localparam int OS   = 16;
    localparam int SYNC = 2;
    localparam int LAT  = 152 + SYNC;
`ifdef RX_MAJORITY_VOTE_EN
    localparam bit VOTE = 1'b1;
`else
    localparam bit VOTE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_line = 1'b1;
    logic       ready = 1'b0;
    logic       dv;
    logic [7:0] dd;
    logic       fe;
    logic       ov;

    uart_receiver #(
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_serial_in  (rx_line),
        .rx_data_ready (ready),
        .rx_data_valid (dv),
        .rx_data       (dd),
        .rx_frame_err  (fe),
        .rx_overrun    (ov)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         ev_kind [int];     // 1 = good frame completes, 2 = bad stop bit
    logic [7:0] ev_data [int];
    bit         m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         m_fe = 1'b0;
    bit         m_ov = 1'b0;
    bit         m_consume;
    logic [7:0] got_q [$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         last_rise = -1;
    bit         prev_dv = 1'b0;
    int         ready_mode = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_got(input string nm, input logic [7:0] exp_q [$]);
        check({nm, "_count"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < got_q.size()) check(nm, {24'h0, got_q[i]}, {24'h0, exp_q[i]});
        end
        got_q.delete();
    endtask

    // Model: each completed frame becomes an event at a known edge, applied to a one-entry buffer.
    always @(posedge clk) begin
        cyc++;
        if (dv && ready) got_q.push_back(dd);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_fe    = 1'b0;
            m_ov    = 1'b0;
        end else begin
            m_consume = m_valid && ready;
            m_fe = 1'b0;
            m_ov = 1'b0;
            if (ev_kind.exists(cyc)) begin
                if (ev_kind[cyc] == 1) begin
                    if (!m_valid || m_consume) begin
                        m_data  = ev_data[cyc];
                        m_valid = 1'b1;
                    end else begin
                        m_ov = 1'b1;
                    end
                end else begin
                    m_fe = 1'b1;
                    if (m_consume) m_valid = 1'b0;
                end
            end else if (m_consume) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("valid", {31'h0, dv}, {31'h0, m_valid});
        if (m_valid) check("data", {24'h0, dd}, {24'h0, m_data});
        check("frame_err", {31'h0, fe}, {31'h0, m_fe});
        check("overrun", {31'h0, ov}, {31'h0, m_ov});
        if (fe) fe_cnt++;
        if (ov) ov_cnt++;
        if (dv && !prev_dv) last_rise = cyc;
        prev_dv = dv;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ready = 1'b0;
                1:       ready = 1'b1;
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic idle(input int n);
        rx_line = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; the following edge is the first to sample the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic glitch,
                              input int ncyc);
        int   p0;
        int   n;
        logic v;
        p0 = cyc + 1;
        n  = 0;
        if (ncyc >= 10 * OS) begin
            if (stop) begin
                ev_kind[p0 + LAT] = 1;
                ev_data[p0 + LAT] = (glitch && !VOTE) ? ~b : b;
            end else begin
                ev_kind[p0 + LAT] = 2;
            end
        end
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < OS; k++) begin
                if (n < ncyc) begin
                    v = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
                    if (glitch && i >= 1 && i <= 8 && k == OS / 2) v = ~v;
                    rx_line = v;
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        end
    endtask

    initial begin
        int         p;
        int         gap;
        logic [7:0] rb;
        logic       rs;
        logic       prev_bad;
        logic [7:0] g_exp;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, dv}, 32'h0);
        check("rst_data", {24'h0, dd}, 32'h0);
        check("rst_ferr", {31'h0, fe}, 32'h0);
        check("rst_ovr", {31'h0, ov}, 32'h0);
        rst_n = 1'b1;
        ready_mode = 1;
        idle(5);

        // Single byte: latency pinned by hand.
        p = cyc + 1;
        send_frame(8'hA5, 1'b1, 1'b0, 160);
        idle(20);
        check("latency", last_rise - p, 154);
        check_got("a5", '{8'hA5});

        // Back-to-back frames.
        send_frame(8'h00, 1'b1, 1'b0, 160);
        send_frame(8'hFF, 1'b1, 1'b0, 160);
        send_frame(8'h55, 1'b1, 1'b0, 160);
        idle(20);
        check_got("b2b", '{8'h00, 8'hFF, 8'h55});
        check("b2b_flags", fe_cnt + ov_cnt, 0);

        // Short low pulse is not a start bit.
        rx_line = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        idle(30);
        check("glitch_none", got_q.size(), 0);
        check("glitch_flags", fe_cnt + ov_cnt, 0);

        // Bad stop bit.
        send_frame(8'h3C, 1'b0, 1'b0, 160);
        idle(20);
        check("ferr_cnt", fe_cnt, 1);
        check("ferr_none", got_q.size(), 0);

        // Bad stop bit followed by a held-low line, then a clean frame.
        send_frame(8'h3C, 1'b0, 1'b0, 160);
        rx_line = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        idle(10);
        send_frame(8'h5A, 1'b1, 1'b0, 160);
        idle(20);
        check("break_ferr_cnt", fe_cnt, 2);
        check_got("after_break", '{8'h5A});

        // Overrun with host stalled.
        ready_mode = 0;
        idle(3);
        send_frame(8'h11, 1'b1, 1'b0, 160);
        send_frame(8'h22, 1'b1, 1'b0, 160);
        idle(20);
        check("ovr_cnt", ov_cnt, 1);
        check("ovr_hold_valid", {31'h0, dv}, 32'h1);
        check("ovr_hold_data", {24'h0, dd}, 32'h11);
        ready_mode = 1;
        idle(5);
        check_got("ovr_drain", '{8'h11});

        // Mid-bit glitches: corrupted by single sampling, survived with voting.
        send_frame(8'h96, 1'b1, 1'b1, 160);
        idle(20);
        g_exp = VOTE ? 8'h96 : 8'h69;
        check_got("vote", '{g_exp});

        // Asynchronous reset in the middle of a data bit.
        ready_mode = 0;
        idle(3);
        send_frame(8'h77, 1'b1, 1'b0, 160);
        send_frame(8'hC3, 1'b1, 1'b0, 60);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, dv}, 32'h0);
        check("arst_data", {24'h0, dd}, 32'h0);
        check("arst_flags", {30'h0, fe, ov}, 32'h0);
        ev_kind.delete();
        ev_data.delete();
        rx_line = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 1;
        idle(5);
        send_frame(8'hE7, 1'b1, 1'b0, 160);
        idle(20);
        check_got("post_rst", '{8'hE7});

        // Randomized traffic with random host backpressure.
        ready_mode = 2;
        prev_bad = 1'b0;
        for (int f = 0; f < 30; f++) begin
            rb  = 8'($urandom);
            rs  = ($urandom_range(0, 5) != 0);
            gap = prev_bad ? 4 + $urandom_range(0, 10)
                           : (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30));
            if (gap > 0) idle(gap);
            send_frame(rb, rs, 1'b0, 160);
            prev_bad = !rs;
        end
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
